uart_rx: RTL and testbench

- Asynchronous serial receiver, 8N1 format, LSB first, 16x oversampled.
- Sits directly upstream of the receive FIFO. Drives the FIFO's `din`/`we` pair and honours its `dir` (space available) flag.
- Bytes that arrive while the FIFO is full are dropped and flagged as overrun.
- Malformed frames are dropped and flagged as framing errors. Both flags are host-visible.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding and frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MIDSTART   = 7;
    localparam int unsigned DATABITS   = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-FIFO write port: byte, write strobe and space-available flag.
interface uart_rx_if;

    logic [7:0] dout;
    logic       we;
    logic       dir;

    modport master (output dout, output we, input dir);
    modport slave  (input dout, input we, output dir);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIVISOR clocks, realignable via restart.
module uart_baud_tick #(
    parameter int unsigned DIVISOR = 26,
    parameter int unsigned DIVW    = 16
) (
    input  logic clk,
    input  logic reset_b,
    input  logic restart,
    output logic tick
);

    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] cnt_d;

    assign tick = (cnt_q == DIVW'(DIVISOR - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver, 16x oversampled, LSB first; writes bytes into the receive FIFO
// and raises sticky overrun / framing flags for the host.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR = 26,
    parameter int unsigned DIVW    = 16
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       rxd,
    input  logic       clr_err,
    output logic       busy,
    output logic       overrun,
    output logic       framing_err,
    uart_rx_if.master  fifo
);

    uart_state_t state_q, state_d;
    logic        sync1_q, sync2_q;
    logic        rxd_s;
    logic [3:0]  sc_q, sc_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dout_q, dout_d;
    logic        we_q, we_d;
    logic        ovr_q, ovr_d;
    logic        fe_q, fe_d;
    logic        tick;
    logic        restart;
    logic        mid_bit;

    assign rxd_s   = sync2_q;
    assign restart = (state_q == IDLE) && !rxd_s;
    assign mid_bit = tick && (sc_q == 4'(OVERSAMPLE - 1));

    uart_baud_tick #(
        .DIVISOR (DIVISOR),
        .DIVW    (DIVW)
    ) u_baud_tick (
        .clk     (clk),
        .reset_b (reset_b),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sc_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            ovr_q   <= ovr_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!rxd_s) state_d = START;
            START: if (tick && (sc_q == 4'(MIDSTART))) state_d = rxd_s ? IDLE : DATA;
            DATA:  if (mid_bit && (bit_q == 3'(DATABITS - 1))) state_d = STOP;
            STOP:  if (mid_bit) state_d = rxd_s ? IDLE : BREAK;
            BREAK: if (rxd_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Error-flag clear is applied first so a coincident new event still sets the flag.
    always_comb begin
        sc_d    = tick ? sc_q + 4'd1 : sc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        we_d    = 1'b0;
        ovr_d   = ovr_q & ~clr_err;
        fe_d    = fe_q & ~clr_err;

        if (state_d != state_q) begin
            sc_d = '0;
        end
        if ((state_q == START) && (state_d == DATA)) begin
            bit_d = '0;
        end
        if ((state_q == DATA) && mid_bit) begin
            shift_d = {rxd_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
        end
        if ((state_q == STOP) && mid_bit) begin
            if (!rxd_s) begin
                fe_d = 1'b1;
            end else if (fifo.dir) begin
                dout_d = shift_q;
                we_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign overrun     = ovr_q;
    assign framing_err = fe_q;
    assign fifo.dout   = dout_q;
    assign fifo.we     = we_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames and compares the FIFO
// writes and error flags against a frame-level reference model.
module tb_uart_rx;

    localparam int unsigned DIV = 4;
    localparam int unsigned BIT = 16 * DIV;

    logic clk     = 1'b0;
    logic reset_b = 1'b0;
    logic rxd     = 1'b1;
    logic clr_err = 1'b0;
    logic busy, overrun, framing_err;

    uart_rx_if bus ();

    uart_rx #(
        .DIVISOR (DIV),
        .DIVW    (16)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .rxd         (rxd),
        .clr_err     (clr_err),
        .busy        (busy),
        .overrun     (overrun),
        .framing_err (framing_err),
        .fifo        (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  got_q[$];
    int unsigned got_cyc[$];
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            got_q.push_back(bus.dout);
            got_cyc.push_back(cyc);
        end
    end

    // Reference model: what the host should see after each complete frame.
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_dout = 8'h00;
    logic        exp_ovr  = 1'b0;
    logic        exp_fe   = 1'b0;
    int          errors   = 0;
    int          checks   = 0;
    int unsigned fall_cyc = 0;

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic dirv);
        if (!stop) begin
            exp_fe = 1'b1;
        end else if (dirv) begin
            exp_q.push_back(b);
            exp_dout = b;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        clks(1);
        rxd = 1'b0;
        fall_cyc = cyc;
        clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            clks(BIT);
        end
        rxd = stop;
        clks(BIT);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        clks(1);
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
    endtask

    task automatic start_scenario();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        bus.dir = 1'b1;
        clks(3);
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_framing: got %b expected 0", framing_err); end
        reset_b = 1'b1;
        clks(10);
    endtask

    task automatic test_single();
        int unsigned lat;
        start_scenario();
        bus.dir = 1'b1;
        drive_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b1);
        clks(20);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_data: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]); end
        lat = (got_cyc.size() > 0) ? got_cyc[0] - fall_cyc : 0;
        checks++; if (lat < 606 || lat > 614) begin errors++; $display("FAIL single_latency: got %0d expected 606..614", lat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
        checks++; if (overrun !== exp_ovr || framing_err !== exp_fe) begin errors++; $display("FAIL single_flags: got %b%b expected %b%b", overrun, framing_err, exp_ovr, exp_fe); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        start_scenario();
        bus.dir = 1'b1;
        foreach (bytes[k]) begin
            drive_frame(bytes[k], 1'b1);
            model_frame(bytes[k], 1'b1, 1'b1);
        end
        clks(20);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (overrun !== exp_ovr || framing_err !== exp_fe) begin errors++; $display("FAIL b2b_flags: got %b%b expected %b%b", overrun, framing_err, exp_ovr, exp_fe); end
    endtask

    task automatic test_glitch();
        logic saw_busy;
        start_scenario();
        saw_busy = 1'b0;
        clks(1);
        rxd = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            clks(1);
            if (i == 20) rxd = 1'b1;
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen: got %b expected 1", saw_busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle_by_36: got %b expected 0", busy); end
        clks(100);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_we: got %0d writes expected 0", got_q.size()); end
        checks++; if (overrun !== exp_ovr || framing_err !== exp_fe) begin errors++; $display("FAIL glitch_flags: got %b%b expected %b%b", overrun, framing_err, exp_ovr, exp_fe); end
    endtask

    task automatic test_break();
        start_scenario();
        bus.dir = 1'b1;
        drive_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b1);
        clks(1000);
        checks++; if (framing_err !== exp_fe) begin errors++; $display("FAIL break_framing: got %b expected %b", framing_err, exp_fe); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b expected 1", busy); end
        pulse_clr();
        clks(1000);
        checks++; if (framing_err !== exp_fe) begin errors++; $display("FAIL break_single_error: got %b expected %b", framing_err, exp_fe); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_hold_busy: got %b expected 1", busy); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL break_we: got %0d writes expected 0", got_q.size()); end
        rxd = 1'b1;
        clks(20);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release: got %b expected 0", busy); end
        drive_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1, 1'b1);
        clks(20);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL break_next_frame: got %0d writes, first %h expected 1 write of %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]); end
    endtask

    task automatic test_overrun();
        start_scenario();
        bus.dir = 1'b0;
        drive_frame(8'h12, 1'b1);
        model_frame(8'h12, 1'b1, 1'b0);
        clks(20);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovr_we: got %0d writes expected 0", got_q.size()); end
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL ovr_flag: got %b expected %b", overrun, exp_ovr); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL ovr_dout_held: got %h expected %h", bus.dout, exp_dout); end
        pulse_clr();
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL ovr_clear: got %b expected %b", overrun, exp_ovr); end
        // clr_err lands on the nominal stop-bit decision cycle of this frame
        fork
            drive_frame(8'h34, 1'b1);
            begin
                clks(1);
                clks(610);
                clr_err = 1'b1;
                clks(1);
                clr_err = 1'b0;
            end
        join
        model_frame(8'h34, 1'b1, 1'b0);
        clks(20);
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL ovr_set_wins: got %b expected %b", overrun, exp_ovr); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovr_we2: got %0d writes expected 0", got_q.size()); end
        bus.dir = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       d;
        start_scenario();
        pulse_clr();
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom_range(0, 255));
            d = 1'($urandom_range(0, 1));
            bus.dir = d;
            drive_frame(b, 1'b1);
            model_frame(b, 1'b1, d);
        end
        bus.dir = 1'b1;
        clks(20);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (overrun !== exp_ovr || framing_err !== exp_fe) begin errors++; $display("FAIL rand_flags: got %b%b expected %b%b", overrun, framing_err, exp_ovr, exp_fe); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL rand_dout: got %h expected %h", bus.dout, exp_dout); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        start_scenario();
        // leave a flag set so the reset has something to clear
        bus.dir = 1'b0;
        drive_frame(8'hC3, 1'b1);
        bus.dir = 1'b1;
        clks(20);
        b = 8'h99;
        clks(1);
        rxd = 1'b0;
        clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            clks(BIT);
        end
        rxd = b[4];
        clks(20);
        reset_b = 1'b0;
        clks(2);
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL mreset_dout: got %h expected 00", bus.dout); end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL mreset_we: got %b expected 0", bus.we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mreset_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0 || framing_err !== 1'b0) begin errors++; $display("FAIL mreset_flags: got %b%b expected 00", overrun, framing_err); end
        rxd = 1'b1;
        reset_b = 1'b1;
        exp_dout = 8'h00; exp_ovr = 1'b0; exp_fe = 1'b0;
        got_q.delete();
        clks(700);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mreset_no_we: got %0d writes expected 0", got_q.size()); end
        drive_frame(8'h66, 1'b1);
        model_frame(8'h66, 1'b1, 1'b1);
        clks(20);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL mreset_next_frame: got %0d writes, first %h expected 1 write of %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL mreset_dout_after: got %h expected %h", bus.dout, exp_dout); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_overrun();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
